regfile_port_ctrl: RTL

- Sequences and shares the register file's single write port and its second read port.
- After reset, sweeps registers 1..31 to INIT_VALUE, then arbitrates the write port between CPU writeback (always wins) and a debug/loader port.
- The debug port uses a req/ack handshake and is serviced only while the CPU is halted.
- Sits between the core's writeback stage, the debug interface, and register_file.

---
 rtl/regfile_ctrl_pkg.sv | 17 +
 rtl/regfile_init_counter.sv | 25 ++
 rtl/regfile_port_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and state encoding for the register-file port controller.
package regfile_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic DBG_RW_WRITE = 1'b1;
  localparam logic DBG_RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DBG_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_init_counter.sv
// Init sweep counter: starts at register 1 and flags the last register index.
module regfile_init_counter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);

  // One extra bit so the count never wraps back to 0 after the top register.
  logic [ADDR_W:0] count;

  // Advance one register per enabled cycle; register 0 is skipped by starting at 1.
  always_ff @(posedge clk) begin
    if (reset)   count <= (ADDR_W+1)'(1);
    else if (en) count <= count + 1'b1;
  end

  assign idx  = count[ADDR_W-1:0];
  assign last = (count == (ADDR_W+1)'(NUM_REGS-1));

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file write port / read port 2 sequencer: init sweep, then CPU-first
// arbitration with a halted-only debug req/ack port.
module regfile_port_ctrl #(
  parameter int                                 NUM_REGS   = regfile_ctrl_pkg::NUM_REGS,
  parameter int                                 ADDR_W     = regfile_ctrl_pkg::ADDR_W,
  parameter int                                 DATA_W     = regfile_ctrl_pkg::DATA_W,
  parameter logic [regfile_ctrl_pkg::DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_halt,
  output logic              cpu_stall,
  output logic              init_done,
  input  logic              dbg_req,
  input  logic              dbg_rw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              rf_rd2_ovr,
  output logic [ADDR_W-1:0] rf_rd2_addr,
  input  logic [DATA_W-1:0] rf_read_data2
);

  import regfile_ctrl_pkg::*;

  state_t            state, state_nxt;
  logic              sweep_en, sweep_last, rd_grant;
  logic [ADDR_W-1:0] sweep_idx;

  regfile_init_counter #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_init_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (sweep_en),
    .idx   (sweep_idx),
    .last  (sweep_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next state and write-port / read-port-2 mux. Everything is quiet while reset
  // is high so a reset landing on a grant cycle neither writes nor steers rd2.
  always_comb begin
    state_nxt       = state;
    sweep_en        = 1'b0;
    rd_grant        = 1'b0;
    dbg_ack         = 1'b0;
    rf_write_enable = 1'b0;
    rf_write_reg    = '0;
    rf_write_data   = '0;
    rf_rd2_ovr      = 1'b0;
    rf_rd2_addr     = '0;
    if (!reset) begin
      case (state)
        ST_INIT: begin
          sweep_en        = 1'b1;
          rf_write_enable = 1'b1;
          rf_write_reg    = sweep_idx;
          rf_write_data   = INIT_VALUE;
          if (sweep_last) state_nxt = ST_RUN;
        end
        ST_RUN, ST_DBG_ACK: begin
          // Ack cycle never grants, which spaces debug ops at least two cycles apart.
          dbg_ack   = (state == ST_DBG_ACK);
          state_nxt = ST_RUN;
          if (cpu_we) begin
            rf_write_enable = 1'b1;
            rf_write_reg    = cpu_waddr;
            rf_write_data   = cpu_wdata;
          end else if (state == ST_RUN && dbg_req && cpu_halt) begin
            state_nxt = ST_DBG_ACK;
            if (dbg_rw == DBG_RW_WRITE) begin
              rf_write_enable = 1'b1;
              rf_write_reg    = dbg_addr;
              rf_write_data   = dbg_wdata;
            end else begin
              rf_rd2_ovr  = 1'b1;
              rf_rd2_addr = dbg_addr;
              rd_grant    = 1'b1;
            end
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  // Capture debug read data at the grant edge; index 0 always reads as zero.
  always_ff @(posedge clk) begin
    if (reset)         dbg_rdata <= '0;
    else if (rd_grant) dbg_rdata <= (dbg_addr == '0) ? '0 : rf_read_data2;
  end

  assign init_done = !reset && (state != ST_INIT);
  assign cpu_stall = !init_done;

endmodule
